// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM state type and tag helpers
// for the 8-way cache set sequencing controller.
package cache_pkg;

    localparam int NWAYS  = 8;
    localparam int TAG_W  = 24;
    localparam int HALT_W = 4;
    localparam int MAIN_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        HFILT,
        PROBE,
        MISS,
        MEM_WAIT,
        FILL,
        RESP
    } ctrlState_t;

    // Per-way compare of the packed halt tags against one key.
    function automatic logic [NWAYS-1:0] haltMatch(
        input logic [NWAYS*HALT_W-1:0] haltTags,
        input logic [HALT_W-1:0]       key
    );
        logic [NWAYS-1:0] hit;
        hit = '0;
        for (int i = 0; i < NWAYS; i++) begin
            hit[i] = (haltTags[i*HALT_W +: HALT_W] == key);
        end
        return hit;
    endfunction

endpackage

// File: rtl/prio_onehot8.sv
// prio_onehot8: lowest-set-bit priority pick over 8 requests,
// giving both a one-hot grant and its 3-bit index.
module prio_onehot8 (
    input  logic [7:0] req,
    output logic [7:0] oneHot,
    output logic [2:0] idx,
    output logic       any
);

    // Scan from the top so the lowest set bit is the last to win.
    always_comb begin
        oneHot = '0;
        idx    = '0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                oneHot = 8'(1) << i;
                idx    = 3'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/cache_set_ctrl.sv
// cache_set_ctrl: one-request-at-a-time read sequencer for an 8-way
// set: halt-tag filter, serial main-tag probe, refill on miss.
module cache_set_ctrl
    import cache_pkg::*;
#(
    parameter int LINE_W  = 256,
    parameter int MEM_TMO = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic [31:0]             cpu_addr,
    output logic                    cpu_ready,
    output logic                    cpu_valid,
    output logic                    cpu_hit,
    output logic                    cpu_err,
    output logic [LINE_W-1:0]       cpu_data,
    output logic                    regWrite,
    output logic [NWAYS-1:0]        decOut1b,
    output logic                    inp_viv,
    output logic [TAG_W-1:0]        in_tag,
    input  logic                    out_viv,
    input  logic [NWAYS*HALT_W-1:0] halt_tags,
    input  logic [MAIN_W-1:0]       outMainTag,
    input  logic [LINE_W-1:0]       outData,
    output logic [LINE_W-1:0]       fill_data,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_ack,
    input  logic [LINE_W-1:0]       mem_data
);

    localparam int CntW = $clog2(MEM_TMO) + 1;

    ctrlState_t        state;
    ctrlState_t        nextState;
    logic [TAG_W-1:0]  tagQ;
    logic [NWAYS-1:0]  candQ;
    logic [NWAYS-1:0]  candFilt;
    logic [NWAYS-1:0]  candRest;
    logic [NWAYS-1:0]  vshadow;
    logic [2:0]        rrPtr;
    logic [2:0]        victimQ;
    logic              victimRrQ;
    logic [LINE_W-1:0] dataQ;
    logic              hitQ;
    logic              errQ;
    logic [CntW-1:0]   memCnt;
    logic              memTmo;
    logic              mainHit;

    logic [NWAYS-1:0]  probeOh;
    logic [2:0]        probeIdx;
    logic              probeAny;
    logic [NWAYS-1:0]  invOh;
    logic [2:0]        invIdx;
    logic              invAny;
    logic              unusedInvOh;

    prio_onehot8 uProbe (
        .req    (candQ),
        .oneHot (probeOh),
        .idx    (probeIdx),
        .any    (probeAny)
    );

    prio_onehot8 uVictim (
        .req    (~vshadow),
        .oneHot (invOh),
        .idx    (invIdx),
        .any    (invAny)
    );

    assign unusedInvOh = ^invOh;

    // Candidate and match terms shared by next-state and datapath.
    always_comb begin
        candFilt = vshadow & haltMatch(halt_tags, tagQ[HALT_W-1:0]);
        candRest = candQ;
        candRest[probeIdx] = 1'b0;
        mainHit  = out_viv && (outMainTag == tagQ[TAG_W-1:HALT_W]);
        memTmo   = (memCnt == CntW'(MEM_TMO - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decision.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (cpu_req) nextState = HFILT;
            end
            HFILT: begin
                nextState = (candFilt == '0) ? MISS : PROBE;
            end
            PROBE: begin
                if (!probeAny)            nextState = MISS;
                else if (mainHit)         nextState = RESP;
                else if (candRest == '0)  nextState = MISS;
            end
            MISS: begin
                nextState = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_ack)      nextState = FILL;
                else if (memTmo)  nextState = RESP;
            end
            FILL: begin
                nextState = RESP;
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath registers: tag, candidates, victim, line, flags, counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tagQ      <= '0;
            candQ     <= '0;
            vshadow   <= '0;
            rrPtr     <= '0;
            victimQ   <= '0;
            victimRrQ <= 1'b0;
            dataQ     <= '0;
            hitQ      <= 1'b0;
            errQ      <= 1'b0;
            memCnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        tagQ <= cpu_addr[31:8];
                        hitQ <= 1'b0;
                        errQ <= 1'b0;
                    end
                end
                HFILT: begin
                    candQ <= candFilt;
                end
                PROBE: begin
                    if (probeAny && mainHit) begin
                        dataQ <= outData;
                        hitQ  <= 1'b1;
                    end else begin
                        candQ <= candRest;
                    end
                end
                MISS: begin
                    victimQ   <= invAny ? invIdx : rrPtr;
                    victimRrQ <= !invAny;
                    memCnt    <= '0;
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        dataQ <= mem_data;
                    end else if (memTmo) begin
                        errQ <= 1'b1;
                    end else begin
                        memCnt <= memCnt + CntW'(1);
                    end
                end
                FILL: begin
                    vshadow[victimQ] <= 1'b1;
                    if (victimRrQ) rrPtr <= rrPtr + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode; the way select is driven only while probing or filling.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_valid = 1'b0;
        cpu_hit   = 1'b0;
        cpu_err   = 1'b0;
        cpu_data  = dataQ;
        regWrite  = 1'b0;
        decOut1b  = '0;
        inp_viv   = 1'b0;
        in_tag    = '0;
        fill_data = '0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        unique case (state)
            IDLE: begin
                cpu_ready = 1'b1;
            end
            PROBE: begin
                decOut1b = probeOh;
            end
            MEM_WAIT: begin
                mem_req  = 1'b1;
                mem_addr = {tagQ, 8'h00};
            end
            FILL: begin
                regWrite  = 1'b1;
                decOut1b  = 8'(1) << victimQ;
                inp_viv   = 1'b1;
                in_tag    = tagQ;
                fill_data = dataQ;
            end
            RESP: begin
                cpu_valid = 1'b1;
                cpu_hit   = hitQ;
                cpu_err   = errQ;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_set_ctrl.sv
// tb_cache_set_ctrl: directed and random reads against a
// way-array reference model with an emulated set datapath.
module tb_cache_set_ctrl;

    logic         clk;
    logic         reset;
    logic         cpu_req;
    logic [31:0]  cpu_addr;
    logic         cpu_ready;
    logic         cpu_valid;
    logic         cpu_hit;
    logic         cpu_err;
    logic [255:0] cpu_data;
    logic         regWrite;
    logic [7:0]   decOut1b;
    logic         inp_viv;
    logic [23:0]  in_tag;
    logic         out_viv;
    logic [31:0]  halt_tags;
    logic [19:0]  outMainTag;
    logic [255:0] outData;
    logic [255:0] fill_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [255:0] mem_data;

    int checks = 0;
    int errors = 0;

    // Reference model: plain per-way arrays plus round-robin pointer.
    bit           refV[8];
    logic [23:0]  refTag[8];
    logic [255:0] refData[8];
    int           refRr;

    // Emulated set storage driven only by the DUT's writes.
    logic         setV[8];
    logic [23:0]  setTag[8];
    logic [255:0] setData[8];

    cache_set_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .cpu_valid  (cpu_valid),
        .cpu_hit    (cpu_hit),
        .cpu_err    (cpu_err),
        .cpu_data   (cpu_data),
        .regWrite   (regWrite),
        .decOut1b   (decOut1b),
        .inp_viv    (inp_viv),
        .in_tag     (in_tag),
        .out_viv    (out_viv),
        .halt_tags  (halt_tags),
        .outMainTag (outMainTag),
        .outData    (outData),
        .fill_data  (fill_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set read mux and packed halt tags.
    always_comb begin
        out_viv    = 1'b0;
        outMainTag = '0;
        outData    = '0;
        halt_tags  = '0;
        for (int i = 0; i < 8; i++) begin
            halt_tags[4*i +: 4] = setTag[i][3:0];
            if (decOut1b[i]) begin
                out_viv    = setV[i];
                outMainTag = setTag[i][23:4];
                outData    = setData[i];
            end
        end
    end

    // Set write port.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                setV[i]    <= 1'b0;
                setTag[i]  <= '0;
                setData[i] <= '0;
            end
        end else if (regWrite) begin
            for (int i = 0; i < 8; i++) begin
                if (decOut1b[i]) begin
                    setV[i]    <= inp_viv;
                    setTag[i]  <= in_tag;
                    setData[i] <= fill_data;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Way select must never be multi-hot; a write needs exactly one way.
    always @(negedge clk) begin
        if (reset) begin
            check("sel_onehot0", 256'($onehot0(decOut1b)), 256'd1);
            if (regWrite) check("wr_onehot", 256'($onehot(decOut1b)), 256'd1);
        end
    end

    function automatic logic [255:0] rndLine();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 8; i++) begin
            refV[i]    = 1'b0;
            refTag[i]  = '0;
            refData[i] = '0;
        end
        refRr = 0;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_ready"}, 256'(cpu_ready), 256'd1);
        check({tag, "_valid"}, 256'(cpu_valid), 256'd0);
        check({tag, "_hit"}, 256'(cpu_hit), 256'd0);
        check({tag, "_err"}, 256'(cpu_err), 256'd0);
        check({tag, "_data"}, cpu_data, 256'd0);
        check({tag, "_wr"}, 256'(regWrite), 256'd0);
        check({tag, "_dec"}, 256'(decOut1b), 256'd0);
        check({tag, "_viv"}, 256'(inp_viv), 256'd0);
        check({tag, "_intag"}, 256'(in_tag), 256'd0);
        check({tag, "_fill"}, fill_data, 256'd0);
        check({tag, "_mreq"}, 256'(mem_req), 256'd0);
        check({tag, "_maddr"}, 256'(mem_addr), 256'd0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset   = 1'b0;
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        #1;
        checkResetOutputs("rst");
        clearModel();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One read transaction, checked against the reference model.
    task automatic runReq(input logic [31:0] addr, input int ackDly,
                          input bit noAck, input bit busyReq,
                          input bit rstAtMem);
        logic [23:0]  tag;
        logic [255:0] line;
        int           cands[$];
        int           hitWay;
        int           k;
        int           victim;
        bit           victimRr;
        int           cyc;
        int           memCyc;
        int           memCnt;
        int           wrCnt;
        bit           memSeen;
        bit           done;
        int           waitCyc;
        logic         gotHit;
        logic         gotErr;
        logic [255:0] gotData;
        logic [7:0]   wrDec;
        logic [23:0]  wrTag;
        logic         wrViv;
        logic [255:0] wrData;

        tag    = addr[31:8];
        line   = rndLine();
        hitWay = -1;
        k      = 0;
        for (int w = 0; w < 8; w++) begin
            if (refV[w] && refTag[w][3:0] == tag[3:0]) begin
                cands.push_back(w);
                if (hitWay < 0 && refTag[w][23:4] == tag[23:4]) begin
                    hitWay = w;
                    k      = cands.size();
                end
            end
        end
        victim   = refRr;
        victimRr = 1'b1;
        for (int w = 7; w >= 0; w--) begin
            if (!refV[w]) begin
                victim   = w;
                victimRr = 1'b0;
            end
        end

        mem_ack = 1'b0;
        waitCyc = 0;
        while (!cpu_ready && waitCyc < 20) begin
            @(negedge clk);
            waitCyc++;
        end
        check("ready_wait", 256'(cpu_ready), 256'd1);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        @(posedge clk);

        cyc     = 0;
        memCyc  = 0;
        memCnt  = 0;
        wrCnt   = 0;
        memSeen = 1'b0;
        done    = 1'b0;
        gotHit  = 1'b0;
        gotErr  = 1'b0;
        gotData = '0;
        wrDec   = '0;
        wrTag   = '0;
        wrViv   = 1'b0;
        wrData  = '0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (busyReq) begin
                cpu_req  = 1'b1;
                cpu_addr = $urandom;
            end else begin
                cpu_req = 1'b0;
            end
            if (mem_req) begin
                if (!memSeen) begin
                    memSeen = 1'b1;
                    memCyc  = cyc;
                    check("mem_addr", 256'(mem_addr), 256'({tag, 8'h00}));
                end
                memCnt++;
                if (rstAtMem) begin
                    reset   = 1'b0;
                    cpu_req = 1'b0;
                    #1;
                    checkResetOutputs("midrst");
                    clearModel();
                    @(negedge clk);
                    reset = 1'b1;
                    return;
                end
                if (!noAck && memCnt == ackDly + 1) begin
                    mem_ack  = 1'b1;
                    mem_data = line;
                end
            end
            if (regWrite) begin
                wrCnt++;
                wrDec  = decOut1b;
                wrTag  = in_tag;
                wrViv  = inp_viv;
                wrData = fill_data;
            end
            if (cpu_valid) begin
                done    = 1'b1;
                gotHit  = cpu_hit;
                gotErr  = cpu_err;
                gotData = cpu_data;
                cpu_req = 1'b0;
            end else if (!mem_req && $urandom_range(0, 3) == 0) begin
                mem_ack  = 1'b1;
                mem_data = rndLine();
            end
        end
        mem_ack = 1'b0;
        cpu_req = 1'b0;

        check("resp_seen", 256'(done), 256'd1);
        if (hitWay >= 0) begin
            check("hit_flag", 256'(gotHit), 256'd1);
            check("hit_err", 256'(gotErr), 256'd0);
            check("hit_data", gotData, refData[hitWay]);
            check("hit_lat", 256'(cyc), 256'(2 + k));
            check("hit_nomem", 256'(memSeen), 256'd0);
            check("hit_nowr", 256'(wrCnt), 256'd0);
        end else begin
            check("miss_mem", 256'(memSeen), 256'd1);
            check("miss_memcyc", 256'(memCyc), 256'(3 + cands.size()));
            check("miss_hit", 256'(gotHit), 256'd0);
            if (noAck) begin
                check("tmo_err", 256'(gotErr), 256'd1);
                check("tmo_lat", 256'(cyc), 256'(memCyc + 64));
                check("tmo_reqcnt", 256'(memCnt), 256'd64);
                check("tmo_nowr", 256'(wrCnt), 256'd0);
            end else begin
                check("miss_err", 256'(gotErr), 256'd0);
                check("miss_data", gotData, line);
                check("miss_lat", 256'(cyc), 256'(memCyc + ackDly + 2));
                check("fill_cnt", 256'(wrCnt), 256'd1);
                check("fill_way", 256'(wrDec), 256'(8'(1) << victim));
                check("fill_tag", 256'(wrTag), 256'(tag));
                check("fill_viv", 256'(wrViv), 256'd1);
                check("fill_data", wrData, line);
                refV[victim]    = 1'b1;
                refTag[victim]  = tag;
                refData[victim] = line;
                if (victimRr) refRr = (refRr + 1) % 8;
            end
        end
    endtask

    logic [19:0] mainPool[4];

    initial begin
        reset    = 1'b0;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        mem_ack  = 1'b0;
        mem_data = '0;
        clearModel();
        #1;
        checkResetOutputs("por");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Cold miss, then hit on the same line.
        runReq(32'h0000_1A00, 2, 1'b0, 1'b0, 1'b0);
        runReq(32'h0000_1A00, 0, 1'b0, 1'b0, 1'b0);
        // Halt-tag alias: second way probed after the first.
        runReq(32'h0001_1A00, 1, 1'b0, 1'b0, 1'b0);
        runReq(32'h0001_1A40, 0, 1'b0, 1'b1, 1'b0);

        // Replacement: nine distinct tags, then the first again.
        applyReset();
        for (int i = 0; i < 9; i++) begin
            runReq({20'(i + 5), 4'h3, 8'h00}, i % 3, 1'b0, 1'b0, 1'b0);
        end
        runReq({20'd5, 4'h3, 8'h00}, 0, 1'b0, 1'b0, 1'b0);

        // Timeout leaves the set untouched; ack on the last cycle wins.
        runReq(32'hDEAD_B000, 0, 1'b1, 1'b0, 1'b0);
        runReq({20'd7, 4'h3, 8'h00}, 0, 1'b0, 1'b0, 1'b0);
        runReq(32'hCAFE_0100, 63, 1'b0, 1'b0, 1'b0);
        runReq(32'hCAFE_0100, 0, 1'b0, 1'b0, 1'b0);

        // Reset during refill, then the same address must miss.
        runReq(32'h1234_5600, 5, 1'b0, 1'b0, 1'b1);
        runReq(32'h1234_5600, 0, 1'b0, 1'b0, 1'b0);

        // Random traffic over a small tag pool to force aliases and evictions.
        mainPool[0] = 20'h00000;
        mainPool[1] = 20'h00001;
        mainPool[2] = 20'h00010;
        mainPool[3] = 20'hABCDE;
        for (int i = 0; i < 150; i++) begin
            runReq({mainPool[$urandom_range(0, 3)],
                    4'($urandom_range(0, 3)),
                    8'($urandom)},
                   $urandom_range(0, 5),
                   ($urandom_range(0, 19) == 0),
                   ($urandom_range(0, 3) == 0),
                   1'b0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
